pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences the 16-bit program counter, instruction register and A/D/M writes of the Hack-style CPU. It also starts and waits on the shared multiply/divide unit for extended C-instructions. It drives the program counter's load/inc/reset controls directly, so each instruction takes 2 cycles, or 3+N cycles for mul/div. A watchdog bounds the mul/div wait, and an instruction counter supports bench and profiling use.

Parameters:
MD_TIMEOUT, 64, maximum cycles spent in WAIT before error; legal range 1..255.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
run  in  1  1 = execute program; 0 = idle in FETCH without fetching
ir  in  16  instruction register contents (current instruction)
alu_zr  in  1  ALU result == 0
alu_ng  in  1  ALU result < 0
md_done  in  1  mul/div unit result valid (level)
ir_load  out  1  capture ROM word at PC into IR
pc_load  out  1  to PC load (jump)
pc_inc  out  1  to PC inc
pc_reset  out  1  to PC reset
a_load  out  1  write A register
d_load  out  1  write D register
m_write  out  1  write data memory at A
wb_sel  out  1  0 = ALU result, 1 = mul/div result to dest registers
md_start  out  1  one-cycle start pulse to mul/div unit
md_op  out  1  0 = multiply, 1 = divide (valid with md_start)
error  out  1  sticky watchdog flag
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- States: FETCH, EXEC, WAIT, WB, HALT. State, error, instr_count and the watchdog are registers. Strobes are combinational from state and ir.
- Reset (reset=0 at an edge): state<=FETCH, error<=0, instr_count<=0, watchdog<=0.
- While reset=0, pc_reset=1 combinationally so the PC clears on the same edge; all other strobes are 0. Reset overrides any state, including mid-WAIT. Any md_done arriving later is ignored.
- Decode:
  - A-instr: ir[15]=0.
  - C-instr: ir[15]=1, ir[14]=1.
  - Extended: ir[15]=1, ir[14]=0, md_op=ir[13].
  - dest = ir[5:3] (A, D, M); jump = ir[2:0] (j1 lt, j2 eq, j3 gt).
  - take = (j1&alu_ng) | (j2&alu_zr) | (j3&~alu_zr&~alu_ng).
- FETCH:
  - run=1: ir_load=1, go EXEC.
  - run=0: all strobes 0, stay in FETCH.
- EXEC:
  - A-instr: a_load=1, pc_inc=1, go FETCH.
  - C-instr: a_load/d_load/m_write = dest bits, wb_sel=0. If take then pc_load=1 else pc_inc=1. Go FETCH.
  - Extended: md_start=1, go WAIT, watchdog<=0. No register writes and no PC change in this cycle.
- WAIT:
  - md_done=1: go WB.
  - Otherwise watchdog++. When watchdog reaches MD_TIMEOUT-1 without md_done: error<=1, go HALT.
  - md_done sampled in the same cycle as timeout takes priority (go WB).
- WB: dest strobes from ir[5:3], wb_sel=1, pc_inc=1, go FETCH. Extended instructions never jump.
- HALT: all strobes 0; leaves only via reset.
- pc_load and pc_inc are never asserted together.
- instr_count increments on every cycle with pc_load or pc_inc asserted, and wraps from all-ones to 0.
- run is sampled only in FETCH. Deasserting run mid-instruction completes that instruction.

Test Plan:
1. reset=0 for 2 cycles, then run=1 with A-instr ir=16'h0005 → pc_reset=1 during reset. Then FETCH(ir_load), EXEC(a_load, pc_inc); instr_count=1 after 2 cycles.
2. C-instr D;JEQ ir=16'hE312, alu_zr=1 → pc_load=1 and pc_inc=0 in EXEC. Same ir with alu_zr=0, alu_ng=0 → pc_inc=1.
3. C-instr AMD=D+1 with no jump → a_load=d_load=m_write=1, wb_sel=0, pc_inc=1.
4. Extended divide ir=16'hA018 (dest DM, md_op=1), md_done raised 5 cycles after md_start → one md_start pulse with md_op=1, 5 WAIT cycles, then WB with d_load=m_write=1, wb_sel=1, pc_inc=1.
5. MD_TIMEOUT=4, extended instr with md_done held 0 → error=1 and HALT after 4 WAIT cycles; no strobes afterwards. reset=0 clears error.
6. reset=0 asserted in WAIT, md_done pulses the next cycle after release → state FETCH, no WB writes. run=0 → remains in FETCH with ir_load=0; instr_count wraps from 16'hFFFF to 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction sequencer for a Hack-style CPU. It drives the PC, IR and A/D/M write strobes,
// and it starts and waits on the shared multiply/divide unit for extended instructions.
module pc_sequencer #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      ir,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic             md_done,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_reset,
  output logic             a_load,
  output logic             d_load,
  output logic             m_write,
  output logic             wb_sel,
  output logic             md_start,
  output logic             md_op,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(MD_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             error_q, error_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_a, is_c, take;
  logic unused_ir;

  assign is_a = ~ir[15];
  assign is_c = ir[15] & ir[14];
  assign take = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_zr & ~alu_ng);
  // The ALU control field is decoded by the datapath, not by the sequencer.
  assign unused_ir = ^ir[12:6];

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d  = state_q;
    error_d  = error_q;
    wdog_d   = wdog_q;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_reset = 1'b0;
    a_load   = 1'b0;
    d_load   = 1'b0;
    m_write  = 1'b0;
    wb_sel   = 1'b0;
    md_start = 1'b0;
    md_op    = 1'b0;

    if (!reset) begin
      pc_reset = 1'b1;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (run) begin
            ir_load = 1'b1;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_a) begin
            a_load  = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end else if (is_c) begin
            a_load  = ir[5];
            d_load  = ir[4];
            m_write = ir[3];
            pc_load = take;
            pc_inc  = ~take;
            state_d = S_FETCH;
          end else begin
            md_start = 1'b1;
            md_op    = ir[13];
            wdog_d   = 8'd0;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          // A result that arrives on the final watchdog cycle still wins over the timeout.
          if (md_done) begin
            state_d = S_WB;
          end else if (wdog_q == WDOG_LAST) begin
            error_d = 1'b1;
            state_d = S_HALT;
          end else begin
            wdog_d = wdog_q + 8'd1;
          end
        end
        S_WB: begin
          a_load  = ir[5];
          d_load  = ir[4];
          m_write = ir[3];
          wb_sel  = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end

    cnt_d = (pc_load | pc_inc) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: state registers use non-blocking assignments only; blocking here would race with readers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      error_q <= 1'b0;
      wdog_q  <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
    end
  end

  assign error       = error_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a default instance and a small one (short watchdog, 4-bit counter)
// share stimulus and are both compared every cycle against a phase-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, alu_zr, alu_ng, md_done;
  logic [15:0] ir;

  logic ir_load_b, pc_load_b, pc_inc_b, pc_reset_b, a_load_b, d_load_b, m_write_b;
  logic wb_sel_b, md_start_b, md_op_b, error_b;
  logic [15:0] cnt_b;
  logic ir_load_s, pc_load_s, pc_inc_s, pc_reset_s, a_load_s, d_load_s, m_write_s;
  logic wb_sel_s, md_start_s, md_op_s, error_s;
  logic [3:0] cnt_s;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.MD_TIMEOUT(64), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .md_done(md_done), .ir_load(ir_load_b), .pc_load(pc_load_b), .pc_inc(pc_inc_b),
    .pc_reset(pc_reset_b), .a_load(a_load_b), .d_load(d_load_b), .m_write(m_write_b),
    .wb_sel(wb_sel_b), .md_start(md_start_b), .md_op(md_op_b), .error(error_b),
    .instr_count(cnt_b)
  );

  pc_sequencer #(.MD_TIMEOUT(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .md_done(md_done), .ir_load(ir_load_s), .pc_load(pc_load_s), .pc_inc(pc_inc_s),
    .pc_reset(pc_reset_s), .a_load(a_load_s), .d_load(d_load_s), .m_write(m_write_s),
    .wb_sel(wb_sel_s), .md_start(md_start_s), .md_op(md_op_s), .error(error_s),
    .instr_count(cnt_s)
  );

  // Strobe bundle order: ir_load pc_load pc_inc pc_reset a_load d_load m_write wb_sel md_start md_op
  logic [9:0] sb_b, sb_s;
  assign sb_b = {ir_load_b, pc_load_b, pc_inc_b, pc_reset_b, a_load_b, d_load_b, m_write_b,
                 wb_sel_b, md_start_b, md_op_b};
  assign sb_s = {ir_load_s, pc_load_s, pc_inc_s, pc_reset_s, a_load_s, d_load_s, m_write_s,
                 wb_sel_s, md_start_s, md_op_s};

  // Reference model: phase 0 idle/fetch, 1 execute, 2 waiting on mul/div, 3 write-back, 4 dead.
  int          ph[2];
  int          waited[2];
  bit          err[2];
  int unsigned cnt[2];

  function automatic int timeout_of(int k);
    return (k == 0) ? 64 : 4;
  endfunction

  function automatic int unsigned mask_of(int k);
    return (k == 0) ? 32'hFFFF : 32'hF;
  endfunction

  function automatic logic [9:0] expect_strobes(int p);
    logic [9:0] s;
    logic lt, eq, gt, jump;
    s = '0;
    if (!reset) return 10'h040;
    lt   = alu_ng;
    eq   = alu_zr;
    gt   = !alu_zr && !alu_ng;
    jump = (ir[2] && lt) || (ir[1] && eq) || (ir[0] && gt);
    case (p)
      0: s[9] = run;
      1: begin
        if (!ir[15]) begin
          s[5] = 1'b1;
          s[7] = 1'b1;
        end else if (ir[14]) begin
          s[5:3] = ir[5:3];
          if (jump) s[8] = 1'b1;
          else      s[7] = 1'b1;
        end else begin
          s[1] = 1'b1;
          s[0] = ir[13];
        end
      end
      3: begin
        s[5:3] = ir[5:3];
        s[2]   = 1'b1;
        s[7]   = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic advance(input int k);
    logic [9:0] s;
    s = expect_strobes(ph[k]);
    if (!reset) begin
      ph[k] = 0; waited[k] = 0; err[k] = 1'b0; cnt[k] = 0;
      return;
    end
    if (s[8] || s[7]) cnt[k] = (cnt[k] + 1) & mask_of(k);
    case (ph[k])
      0: if (run) ph[k] = 1;
      1: begin
        ph[k] = (!ir[15] || ir[14]) ? 0 : 2;
        waited[k] = 0;
      end
      2: begin
        if (md_done) ph[k] = 3;
        else begin
          waited[k]++;
          if (waited[k] == timeout_of(k)) begin
            err[k] = 1'b1;
            ph[k]  = 4;
          end
        end
      end
      3: ph[k] = 0;
      default: ph[k] = 4;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare both instances at the falling edge, then step the model across the rising edge.
  task automatic tick();
    @(negedge clk);
    check("b_strobes", 32'(sb_b), 32'(expect_strobes(ph[0])));
    check("b_error",   32'(error_b), 32'(err[0]));
    check("b_count",   32'(cnt_b), cnt[0]);
    check("s_strobes", 32'(sb_s), 32'(expect_strobes(ph[1])));
    check("s_error",   32'(error_s), 32'(err[1]));
    check("s_count",   32'(cnt_s), cnt[1]);
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; waited[k] = 0; err[k] = 1'b0; cnt[k] = 0;
    end
    reset = 1'b0; run = 1'b0; ir = 16'h0000; alu_zr = 1'b0; alu_ng = 1'b0; md_done = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then one A-instruction.
    settle();
    check("t1_pc_reset", 32'(pc_reset_b), 32'd1);
    tick();
    tick();
    reset = 1'b1; run = 1'b1; ir = 16'h0005;
    settle();
    check("t1_ir_load", 32'(ir_load_b), 32'd1);
    tick();
    settle();
    check("t1_a_load_inc", 32'({a_load_b, pc_inc_b}), 32'b11);
    tick();
    check("t1_count", 32'(cnt_b), 32'd1);

    // D;JEQ taken then not taken.
    ir = 16'hE312; alu_zr = 1'b1;
    tick();
    settle();
    check("t2_taken", 32'({pc_load_b, pc_inc_b, d_load_b}), 32'b101);
    tick();
    alu_zr = 1'b0; alu_ng = 1'b0;
    tick();
    settle();
    check("t2_not_taken", 32'({pc_load_b, pc_inc_b}), 32'b01);
    tick();

    // AMD=D+1, no jump.
    ir = 16'hE7F8;
    tick();
    settle();
    check("t3_amd", 32'({a_load_b, d_load_b, m_write_b, wb_sel_b, pc_inc_b}), 32'b11101);
    tick();

    // Extended divide; the small instance times out in parallel.
    ir = 16'hA018;
    tick();
    settle();
    check("t4_start", 32'({md_start_b, md_op_b}), 32'b11);
    tick();
    for (int i = 0; i < 5; i++) begin
      md_done = (i == 4);
      settle();
      check("t4_wait_quiet", 32'({md_start_b, pc_inc_b, pc_load_b}), 32'd0);
      tick();
    end
    md_done = 1'b0;
    settle();
    check("t4_wb", 32'({a_load_b, d_load_b, m_write_b, wb_sel_b, pc_inc_b}), 32'b01111);
    check("t5_error", 32'(error_s), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t5_halt_quiet", 32'(sb_s), 32'd0);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_error_clear", 32'(error_s), 32'd0);

    // Reset in the middle of WAIT, late md_done is ignored.
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; md_done = 1'b1; run = 1'b0;
    settle();
    check("t6_no_wb", 32'({d_load_b, m_write_b, wb_sel_b, ir_load_b}), 32'd0);
    tick();
    md_done = 1'b0;
    tick();
    tick();

    // Counter wrap on the 4-bit instance.
    run = 1'b1; ir = 16'h0005;
    for (int i = 0; i < 15; i++) begin
      tick();
      tick();
    end
    check("t6_count_max", 32'(cnt_s), 32'hF);
    tick();
    tick();
    check("t6_count_wrap", 32'(cnt_s), 32'h0);
    check("t6_count_big", 32'(cnt_b), 32'd16);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (ph[0] == 0) begin
        case ($urandom_range(0, 2))
          0:       ir = {1'b0, 15'($urandom)};
          1:       ir = {3'b111, 13'($urandom)};
          default: ir = {2'b10, 14'($urandom)};
        endcase
      end
      reset   = ($urandom_range(0, 49) != 0);
      run     = ($urandom_range(0, 9) != 0);
      alu_zr  = 1'($urandom);
      alu_ng  = 1'($urandom);
      md_done = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
